despread_symbol_timing_ctrl: RTL and testbench

Symbol-timing controller downstream of the 20-tap matched-filter despreader in the 802.11b 1 Mbps DSSS receiver.
- Consumes the despreader's per-sample correlator output (one result per input sample, SPS per symbol).
- Finds the chip phase with maximum correlation energy, then emits one despread symbol per symbol period at that phase.
- Supervises lock and restarts acquisition on loss. Feeds the DBPSK demodulator.

---
 rtl/dsss_timing_pkg.sv | 27 ++
 rtl/despread_mag_abs.sv | 42 ++++
 rtl/despread_symbol_timing_ctrl.sv | 237 +++++++++++++++++++++++
 tb/tb_despread_symbol_timing_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsss_timing_pkg.sv
// Shared types and sizing for the DSSS despreader symbol-timing controller.
package dsss_timing_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_ACQUIRE,
        ST_DECIDE,
        ST_TRACK
    } state_t;

    localparam int SPS_DEF = 20;
    localparam int MAG_W   = 33;

    function automatic int acc_width(input int acq_symbols);
        return MAG_W + $clog2(acq_symbols);
    endfunction

    function automatic logic [4:0] phase_inc(input logic [4:0] p, input int sps);
        return (p == 5'(sps - 1)) ? 5'd0 : p + 5'd1;
    endfunction

    function automatic logic [4:0] phase_dec(input logic [4:0] p, input int sps);
        return (p == 5'd0) ? 5'(sps - 1) : p - 5'd1;
    endfunction

endpackage

// File: rtl/despread_mag_abs.sv
// Registered |I|+|Q| of one despreader sample; 1-cycle latency, no backpressure.
// |-2^31| is carried exactly in the 33-bit result.
module despread_mag_abs
    import dsss_timing_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             i_vld,
    input  logic [31:0]      i_i,
    input  logic [31:0]      i_q,
    output logic             o_vld,
    output logic [MAG_W-1:0] o_mag
);

    logic [MAG_W-1:0] w_ext_i;
    logic [MAG_W-1:0] w_ext_q;
    logic [MAG_W-1:0] w_abs_i;
    logic [MAG_W-1:0] w_abs_q;
    logic             r_vld;
    logic [MAG_W-1:0] r_mag;

    assign w_ext_i = {i_i[31], i_i};
    assign w_ext_q = {i_q[31], i_q};
    assign w_abs_i = i_i[31] ? (MAG_W'(0) - w_ext_i) : w_ext_i;
    assign w_abs_q = i_q[31] ? (MAG_W'(0) - w_ext_q) : w_ext_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_vld <= 1'b0;
            r_mag <= '0;
        end else begin
            r_vld <= i_vld;
            if (i_vld) begin
                r_mag <= w_abs_i + w_abs_q;
            end
        end
    end

    assign o_vld = r_vld;
    assign o_mag = r_mag;

endmodule

// File: rtl/despread_symbol_timing_ctrl.sv
// Picks the max-energy chip phase from the despreader stream and emits one symbol per period there;
// symbol out 1 cycle after its sample, no backpressure. EARLY_LATE_EN adds early/late phase tracking.
module despread_symbol_timing_ctrl
    import dsss_timing_pkg::*;
#(
    parameter int          SPS         = SPS_DEF,
    parameter int          ACQ_SYMBOLS = 8,
    parameter logic [31:0] LOCK_THRESH = 32'd4000000,
    parameter int          LOSS_LIMIT  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        acq_restart,
    input  logic [31:0] despread_i,
    input  logic [31:0] despread_q,
    input  logic        despread_valid,
    output logic [31:0] symbol_i,
    output logic [31:0] symbol_q,
    output logic        symbol_valid,
    output logic        locked,
    output logic [4:0]  best_phase
);

    localparam int ACC_W     = acc_width(ACQ_SYMBOLS);
    localparam int ACQ_CNT_W = $clog2(ACQ_SYMBOLS * SPS);
    localparam int WEAK_W    = $clog2(LOSS_LIMIT + 1);
    localparam logic [ACC_W-1:0] DECIDE_THRESH = ACC_W'(LOCK_THRESH) * ACC_W'(ACQ_SYMBOLS);
    localparam logic [MAG_W-1:0] SYM_THRESH    = MAG_W'(LOCK_THRESH);

    state_t               r_state;
    logic [4:0]           r_phase;
    logic [4:0]           r_phase_d;
    logic [4:0]           r_idx;
    logic [4:0]           r_arg;
    logic [4:0]           r_best;
    logic [ACQ_CNT_W-1:0] r_acq_cnt;
    logic [ACC_W-1:0]     r_acc [SPS];
    logic [ACC_W-1:0]     r_max;
    logic [WEAK_W-1:0]    r_weak;
    logic [31:0]          r_sym_i;
    logic [31:0]          r_sym_q;
    logic                 r_sym_vld;
    logic                 r_locked;

    logic                 w_counted;
    logic                 w_mag_vld;
    logic [MAG_W-1:0]     w_mag;
    logic                 w_cand_gt;
    logic [ACC_W-1:0]     w_cand_max;
    logic [4:0]           w_cand_arg;
    logic                 w_at_best;

`ifdef EARLY_LATE_EN
    localparam logic signed [ACC_W:0] EL_THRESH = (ACC_W+1)'(LOCK_THRESH);
    logic signed [ACC_W:0] r_el_diff;
    logic [2:0]            r_el_sym;
    logic                  r_el_pend;
    logic                  r_el_up;
    logic [4:0]            w_ph_plus;
    logic [4:0]            w_ph_minus;
    logic [4:0]            w_ph_mid;
    logic signed [ACC_W:0] w_el_mag;
    logic signed [ACC_W:0] w_el_abs;

    assign w_ph_plus  = phase_inc(r_best, SPS);
    assign w_ph_minus = phase_dec(r_best, SPS);
    assign w_ph_mid   = 5'((int'(r_best) + SPS / 2) % SPS);
    assign w_el_mag   = $signed({{(ACC_W + 1 - MAG_W){1'b0}}, w_mag});
    assign w_el_abs   = r_el_diff[ACC_W] ? -r_el_diff : r_el_diff;
`endif

    // Samples are tagged at the input so the magnitude, its phase and the acquisition count stay aligned.
    assign w_counted = despread_valid &&
                       (r_state == ST_ACQUIRE || r_state == ST_DECIDE || r_state == ST_TRACK);
    assign w_at_best = despread_valid && (r_phase == r_best);

    assign w_cand_gt  = r_acc[r_idx] > r_max;
    assign w_cand_max = w_cand_gt ? r_acc[r_idx] : r_max;
    assign w_cand_arg = w_cand_gt ? r_idx : r_arg;

    despread_mag_abs u_mag (
        .clk   (clk),
        .reset (reset),
        .i_vld (w_counted),
        .i_i   (despread_i),
        .i_q   (despread_q),
        .o_vld (w_mag_vld),
        .o_mag (w_mag)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_phase   <= '0;
            r_phase_d <= '0;
            r_idx     <= '0;
            r_arg     <= '0;
            r_best    <= '0;
            r_acq_cnt <= '0;
            for (int k = 0; k < SPS; k++) begin
                r_acc[k] <= '0;
            end
            r_max     <= '0;
            r_weak    <= '0;
            r_sym_i   <= '0;
            r_sym_q   <= '0;
            r_sym_vld <= 1'b0;
            r_locked  <= 1'b0;
`ifdef EARLY_LATE_EN
            r_el_diff <= '0;
            r_el_sym  <= '0;
            r_el_pend <= 1'b0;
            r_el_up   <= 1'b0;
`endif
        end else begin
            r_sym_vld <= 1'b0;
            if (w_counted) begin
                r_phase   <= phase_inc(r_phase, SPS);
                r_phase_d <= r_phase;
            end
            if (!enable) begin
                r_state  <= ST_IDLE;
                r_locked <= 1'b0;
            end else if (acq_restart && r_state != ST_IDLE) begin
                r_state  <= ST_CLEAR;
                r_idx    <= '0;
                r_locked <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_state <= ST_CLEAR;
                        r_idx   <= '0;
                    end
                    ST_CLEAR: begin
                        r_acc[r_idx] <= '0;
                        r_phase      <= '0;
                        r_acq_cnt    <= '0;
                        r_max        <= '0;
                        r_arg        <= '0;
                        r_weak       <= '0;
`ifdef EARLY_LATE_EN
                        r_el_diff    <= '0;
                        r_el_sym     <= '0;
                        r_el_pend    <= 1'b0;
`endif
                        if (r_idx == 5'(SPS - 1)) begin
                            r_idx   <= '0;
                            r_state <= ST_ACQUIRE;
                        end else begin
                            r_idx <= r_idx + 5'd1;
                        end
                    end
                    ST_ACQUIRE: begin
                        if (w_mag_vld) begin
                            r_acc[r_phase_d] <= r_acc[r_phase_d] + ACC_W'(w_mag);
                            r_acq_cnt        <= r_acq_cnt + 1'b1;
                            if (r_acq_cnt == ACQ_CNT_W'(ACQ_SYMBOLS * SPS - 1)) begin
                                r_state <= ST_DECIDE;
                                r_idx   <= '0;
                            end
                        end
                    end
                    ST_DECIDE: begin
                        r_max <= w_cand_max;
                        r_arg <= w_cand_arg;
                        if (r_idx == 5'(SPS - 1)) begin
                            r_idx <= '0;
                            if (w_cand_max >= DECIDE_THRESH) begin
                                r_best   <= w_cand_arg;
                                r_state  <= ST_TRACK;
                                r_locked <= 1'b1;
                            end else begin
                                r_state <= ST_CLEAR;
                            end
                        end else begin
                            r_idx <= r_idx + 5'd1;
                        end
                    end
                    ST_TRACK: begin
                        if (w_at_best) begin
                            r_sym_i   <= despread_i;
                            r_sym_q   <= despread_q;
                            r_sym_vld <= 1'b1;
                        end
                        if (w_mag_vld && r_phase_d == r_best) begin
                            if (w_mag < SYM_THRESH) begin
                                if (r_weak == WEAK_W'(LOSS_LIMIT - 1)) begin
                                    r_state  <= ST_CLEAR;
                                    r_idx    <= '0;
                                    r_locked <= 1'b0;
                                end else begin
                                    r_weak <= r_weak + 1'b1;
                                end
                            end else begin
                                r_weak <= '0;
                            end
                        end
`ifdef EARLY_LATE_EN
                        if (w_mag_vld) begin
                            if (r_phase_d == w_ph_plus) begin
                                r_el_diff <= r_el_diff + w_el_mag;
                            end else if (r_phase_d == w_ph_minus) begin
                                r_el_diff <= r_el_diff - w_el_mag;
                            end else if (r_phase_d == r_best) begin
                                r_el_sym <= r_el_sym + 3'd1;
                                if (r_el_sym == 3'd7) begin
                                    r_el_diff <= '0;
                                    if (w_el_abs > EL_THRESH) begin
                                        r_el_pend <= 1'b1;
                                        r_el_up   <= !r_el_diff[ACC_W];
                                    end
                                end
                            end
                        end
                        // Moving at mid-symbol keeps exactly one strobe per (stretched or shrunk) period.
                        if (r_el_pend && despread_valid && r_phase == w_ph_mid) begin
                            r_best    <= r_el_up ? w_ph_plus : w_ph_minus;
                            r_el_pend <= 1'b0;
                        end
`endif
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign symbol_i     = r_sym_i;
    assign symbol_q     = r_sym_q;
    assign symbol_valid = r_sym_vld;
    assign locked       = r_locked;
    assign best_phase   = r_best;

endmodule

// File: tb/tb_despread_symbol_timing_ctrl.sv
// Self-checking bench for despread_symbol_timing_ctrl: lock, tie-break, no-lock loop, loss, restart, enable.
module tb_despread_symbol_timing_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        acq_restart;
    logic [31:0] despread_i;
    logic [31:0] despread_q;
    logic        despread_valid;
    logic [31:0] symbol_i;
    logic [31:0] symbol_q;
    logic        symbol_valid;
    logic        locked;
    logic [4:0]  best_phase;

    always #5 clk = ~clk;

    despread_symbol_timing_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .acq_restart    (acq_restart),
        .despread_i     (despread_i),
        .despread_q     (despread_q),
        .despread_valid (despread_valid),
        .symbol_i       (symbol_i),
        .symbol_q       (symbol_q),
        .symbol_valid   (symbol_valid),
        .locked         (locked),
        .best_phase     (best_phase)
    );

    int          checks   = 0;
    int          failures = 0;
    int          pat_i [20];
    int          g_s;
    int          lock_rise;
    int          lock_fall;
    int          strobes;
    int          last_strobe;
    int          min_gap;
    int          max_gap;
    int          restart_at;
    int          sb_from;
    int          sb_phase;
    logic        sb_en;
    logic        prev_locked;
    logic [31:0] seen_mask;
    logic [31:0] sb_q [$];

    // Sample s (s=0 on the first edge after reset release) sits at controller phase (s+19)%20:
    // one IDLE edge plus 20 CLEAR edges precede the first acquired sample.
    task automatic clear_stats();
        lock_rise   = -1;
        lock_fall   = -1;
        strobes     = 0;
        last_strobe = -1;
        min_gap     = 1000;
        max_gap     = 0;
        seen_mask   = '0;
    endtask

    task automatic set_pattern(input int base, input int p1, input int v1, input int p2, input int v2);
        for (int k = 0; k < 20; k++) pat_i[k] = base;
        pat_i[p1] = v1;
        pat_i[p2] = v2;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset          = 1'b0;
        enable         = 1'b1;
        acq_restart    = 1'b0;
        despread_valid = 1'b0;
        despread_i     = '0;
        despread_q     = '0;
        repeat (3) @(negedge clk);
        reset       = 1'b1;
        g_s         = 0;
        prev_locked = 1'b0;
        sb_en       = 1'b0;
        restart_at  = -1;
        clear_stats();
    endtask

    task automatic stream(input int n);
        int          ph;
        int          gap;
        logic [31:0] exp_i;
        for (int k = 0; k < n; k++) begin
            ph             = (g_s + 19) % 20;
            despread_i     = pat_i[ph];
            despread_q     = '0;
            despread_valid = 1'b1;
            acq_restart    = (g_s == restart_at);
            if (sb_en && g_s >= sb_from && ph == sb_phase) sb_q.push_back(pat_i[ph]);
            @(posedge clk);
            @(negedge clk);
            acq_restart = 1'b0;
            if (locked && !prev_locked && lock_rise < 0) lock_rise = g_s;
            if (!locked && prev_locked && lock_fall < 0) lock_fall = g_s;
            prev_locked = locked;
            seen_mask[best_phase] = 1'b1;
            if (symbol_valid) begin
                strobes++;
                if (last_strobe >= 0) begin
                    gap = g_s - last_strobe;
                    if (gap < min_gap) min_gap = gap;
                    if (gap > max_gap) max_gap = gap;
                end
                last_strobe = g_s;
                if (sb_en) begin
                    checks++;
                    if (sb_q.size() == 0) begin
                        failures++;
                        $display("FAIL sb_unexpected: strobe at sample %0d symbol_i=%0d, none expected", g_s, symbol_i);
                    end else begin
                        exp_i = sb_q.pop_front();
                        if (symbol_i !== exp_i || symbol_q !== 32'd0) begin
                            failures++;
                            $display("FAIL sb_symbol: sample %0d got i=%0d q=%0d want i=%0d q=0",
                                     g_s, symbol_i, symbol_q, exp_i);
                        end
                    end
                end
            end
            g_s++;
        end
    endtask

    task automatic test_reset();
        reset          = 1'b0;
        enable         = 1'b0;
        acq_restart    = 1'b0;
        despread_valid = 1'b0;
        despread_i     = '0;
        despread_q     = '0;
        #1;
        checks++;
        if ({symbol_i, symbol_q, symbol_valid, locked, best_phase} !== 71'd0) begin
            failures++;
            $display("FAIL reset_por: outputs i=%0d q=%0d v=%0b l=%0b bp=%0d, want all 0",
                     symbol_i, symbol_q, symbol_valid, locked, best_phase);
        end
        // Lock, then pull reset mid-cycle: outputs must clear before the next edge.
        do_reset();
        set_pattern(1000, 7, 5000000, 7, 5000000);
        stream(215);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({symbol_i, symbol_q, symbol_valid, locked, best_phase} !== 71'd0) begin
            failures++;
            $display("FAIL reset_mid_track: outputs i=%0d q=%0d v=%0b l=%0b bp=%0d, want all 0",
                     symbol_i, symbol_q, symbol_valid, locked, best_phase);
        end
    endtask

    task automatic test_lock();
        do_reset();
        set_pattern(1000, 7, 5000000, 7, 5000000);
        sb_en    = 1'b1;
        sb_from  = 202;
        sb_phase = 7;
        stream(302);
        sb_en = 1'b0;
        checks++;
        if (lock_rise !== 201) begin
            failures++;
            $display("FAIL lock_time: locked rose after sample %0d, want 201", lock_rise);
        end
        checks++;
        if (best_phase !== 5'd7) begin
            failures++;
            $display("FAIL lock_phase: best_phase=%0d want 7", best_phase);
        end
        checks++;
        if (strobes !== 5) begin
            failures++;
            $display("FAIL lock_strobes: %0d strobes, want 5", strobes);
        end
        checks++;
        if (sb_q.size() !== 0) begin
            failures++;
            $display("FAIL lock_sb_drain: %0d expected symbols never arrived, want 0", sb_q.size());
        end
        sb_q.delete();
    endtask

    task automatic test_tie();
        do_reset();
        set_pattern(1000, 3, 5000000, 12, 5000000);
        stream(230);
        checks++;
        if (best_phase !== 5'd3 || locked !== 1'b1) begin
            failures++;
            $display("FAIL tie_phase: best_phase=%0d locked=%0b, want 3 and 1", best_phase, locked);
        end
    endtask

    task automatic test_no_lock();
        do_reset();
        set_pattern(1000, 0, 1000, 0, 1000);
        stream(600);
        checks++;
        if (lock_rise !== -1 || best_phase !== 5'd0) begin
            failures++;
            $display("FAIL nolock_weak: lock_rise=%0d best_phase=%0d, want -1 and 0", lock_rise, best_phase);
        end
        // The acquisition loop must still be cycling: a real peak locks within two loop periods.
        set_pattern(1000, 7, 5000000, 7, 5000000);
        stream(450);
        checks++;
        if (lock_rise < 0 || locked !== 1'b1) begin
            failures++;
            $display("FAIL nolock_retry: lock_rise=%0d locked=%0b, want lock", lock_rise, locked);
        end
    endtask

    task automatic test_loss();
        do_reset();
        set_pattern(1000, 7, 5000000, 7, 5000000);
        stream(210);
        pat_i[7] = 1000;
        stream(95);
        checks++;
        if (lock_fall !== 289) begin
            failures++;
            $display("FAIL loss_time: locked fell after sample %0d, want 289", lock_fall);
        end
        do_reset();
        set_pattern(1000, 7, 5000000, 7, 5000000);
        stream(210);
        for (int sym = 0; sym < 9; sym++) begin
            pat_i[7] = (sym == 3 || sym >= 7) ? 5000000 : 1000;
            stream(20);
        end
        checks++;
        if (lock_fall !== -1 || locked !== 1'b1) begin
            failures++;
            $display("FAIL loss_313: lock_fall=%0d locked=%0b, want -1 and 1", lock_fall, locked);
        end
    endtask

    task automatic test_restart();
        do_reset();
        set_pattern(1000, 7, 5000000, 7, 5000000);
        stream(215);
        clear_stats();
        restart_at = 228;
        stream(14);
        checks++;
        if (locked !== 1'b0) begin
            failures++;
            $display("FAIL restart_lock: locked=%0b after restart, want 0", locked);
        end
        stream(150);
        checks++;
        if (strobes !== 0) begin
            failures++;
            $display("FAIL restart_strobes: %0d strobes after restart, want 0", strobes);
        end
        checks++;
        if (best_phase !== 5'd7) begin
            failures++;
            $display("FAIL restart_hold: best_phase=%0d, want held 7", best_phase);
        end
    endtask

    task automatic test_enable();
        do_reset();
        set_pattern(1000, 7, 5000000, 7, 5000000);
        stream(215);
        enable = 1'b0;
        stream(1);
        checks++;
        if (locked !== 1'b0) begin
            failures++;
            $display("FAIL enable_low: locked=%0b, want 0", locked);
        end
        enable = 1'b1;
        clear_stats();
        stream(210);
        checks++;
        if (lock_rise !== 417 || best_phase !== 5'd11) begin
            failures++;
            $display("FAIL enable_relock: lock_rise=%0d best_phase=%0d, want 417 and 11", lock_rise, best_phase);
        end
    endtask

`ifdef EARLY_LATE_EN
    task automatic test_early_late();
        do_reset();
        set_pattern(1000, 7, 5000000, 7, 5000000);
        stream(215);
        clear_stats();
        set_pattern(1000, 7, 4000000, 8, 5000000);
        pat_i[9] = 3000000;
        stream(240);
        checks++;
        if (seen_mask[8] !== 1'b1) begin
            failures++;
            $display("FAIL el_move: best_phase never reached 8, final=%0d", best_phase);
        end
        checks++;
        if (min_gap < 19 || max_gap > 21 || locked !== 1'b1) begin
            failures++;
            $display("FAIL el_gaps: gap range %0d..%0d locked=%0b, want 19..21 and 1", min_gap, max_gap, locked);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_lock();
        test_tie();
        test_no_lock();
        test_loss();
        test_restart();
        test_enable();
`ifdef EARLY_LATE_EN
        test_early_late();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
